// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: funct3 codes, FSM states
// and the lane-offset helper used by both store and load paths.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Address bits below the access size never steer a lane.
    function automatic logic [1:0] lane_offset(input logic [2:0] f3, input logic [1:0] lo);
        logic [1:0] off;
        off = lo;
        if (f3 == F3_H || f3 == F3_HU)
            off = {lo[1], 1'b0};
        else if (f3 == F3_W)
            off = 2'b00;
        return off;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Ready/valid data-memory port between the memory-access stage (master)
// and the data memory (slave).
interface mem_access_stage_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ready, rdata
    );

endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword from a read word and sign- or
// zero-extends it according to funct3.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[8*offset +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0, half_sel};
            F3_W:    data = rdata;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: drives the data-memory port, stalls the front of the
// pipe while memory is busy, and registers MEM/WB. Optional misaligned-access
// trap is enabled with `define MEM_MISALIGN_TRAP_EN.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                RegWrite,
    input  logic                MemWrite,
    input  logic                MemRead,
    input  logic                MemtoReg,
    input  logic [31:0]         result,
    input  logic [31:0]         writeData,
    input  logic [4:0]          rd,
    input  logic [2:0]          funct3,
    mem_access_stage_if.master  dmem,
    output logic                stall,
    output logic                RegWrite_wb,
    output logic                MemtoReg_wb,
    output logic [4:0]          rd_wb,
    output logic [31:0]         result_wb,
    output logic [31:0]         readData_wb,
    output logic                bus_error
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                misalign
`endif
);

    mem_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic        pending;
    logic        is_load;
    logic        store_valid;
    logic        trap;
    logic        needs_mem;
    logic        in_wait;
    logic        timeout_hit;
    logic        capture;
    logic [1:0]  offset;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] aligned;
    logic [31:0] load_word;

    assign pending     = MemRead | MemWrite;
    assign is_load     = MemRead & ~MemWrite;
    assign store_valid = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    assign offset      = lane_offset(funct3, result[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = pending &&
                  ((((funct3 == F3_H) || (is_load && funct3 == F3_HU)) && result[0]) ||
                   ((funct3 == F3_W) && (result[1:0] != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    // Stores with an undefined size complete locally without touching memory.
    assign needs_mem   = pending && !(MemWrite && !store_valid) && !trap;
    assign in_wait     = (state_reg == WAIT);
    assign timeout_hit = in_wait && !dmem.ready && (cnt_reg == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        be    = 4'b0000;
        wdata = writeData;
        if (MemWrite) begin
            case (funct3)
                F3_B: begin
                    be    = 4'b0001 << offset;
                    wdata = {4{writeData[7:0]}};
                end
                F3_H: begin
                    be    = offset[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{writeData[15:0]}};
                end
                F3_W:    be = 4'b1111;
                default: be = 4'b0000;
            endcase
        end
    end

    assign dmem.req   = rstn && (in_wait || needs_mem);
    assign dmem.we    = MemWrite;
    assign dmem.addr  = {result[31:2], 2'b00};
    assign dmem.be    = be;
    assign dmem.wdata = wdata;

    assign stall     = rstn && !dmem.ready &&
                       ((in_wait && !timeout_hit) || (!in_wait && needs_mem));
    assign bus_error = rstn && timeout_hit;
    assign capture   = !stall && !timeout_hit && !(!in_wait && trap);

    mem_load_align u_load_align (
        .rdata  (dmem.rdata),
        .offset (offset),
        .funct3 (funct3),
        .data   (aligned)
    );

    assign load_word = is_load ? aligned : 32'h0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (needs_mem && !dmem.ready) begin
                        state_reg <= WAIT;
                        cnt_reg   <= '0;
                    end
                end
                WAIT: begin
                    if (dmem.ready || cnt_reg == CNT_W'(TIMEOUT_CYCLES))
                        state_reg <= IDLE;
                    else
                        cnt_reg <= cnt_reg + 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Anything other than a completion loads a bubble.
    always_ff @(posedge clk) begin
        if (!rstn || !capture) begin
            RegWrite_wb <= 1'b0;
            MemtoReg_wb <= 1'b0;
            rd_wb       <= 5'd0;
            result_wb   <= 32'h0;
            readData_wb <= 32'h0;
        end else begin
            RegWrite_wb <= RegWrite;
            MemtoReg_wb <= MemtoReg;
            rd_wb       <= rd;
            result_wb   <= result;
            readData_wb <= load_word;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (!rstn)
            misalign <= 1'b0;
        else
            misalign <= !in_wait && trap;
    end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, random
// transactions against a behavioural model, timeout and reset sequences.
module tb_mem_access_stage;

    localparam int TO = 255;

    logic        clk;
    logic        rstn;
    logic        RegWrite, MemWrite, MemRead, MemtoReg;
    logic [31:0] result, writeData;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        stall, RegWrite_wb, MemtoReg_wb, bus_error;
    logic [4:0]  rd_wb;
    logic [31:0] result_wb, readData_wb;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    mem_access_stage_if dmem_bus();

    mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .RegWrite    (RegWrite),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .MemtoReg    (MemtoReg),
        .result      (result),
        .writeData   (writeData),
        .rd          (rd),
        .funct3      (funct3),
        .dmem        (dmem_bus),
        .stall       (stall),
        .RegWrite_wb (RegWrite_wb),
        .MemtoReg_wb (MemtoReg_wb),
        .rd_wb       (rd_wb),
        .result_wb   (result_wb),
        .readData_wb (readData_wb),
        .bus_error   (bus_error)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign    (misalign)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        mr, mw, rw, m2r;
        logic [2:0]  f3;
        logic [31:0] addr, wd, rdata;
        logic [4:0]  rd;
        int          lat;
        logic        exp_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_rd;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic mr, mw, rw, m2r, input logic [2:0] f3,
                                input logic [31:0] addr, wd, rdata, input logic [4:0] r,
                                input int lat, input logic exp_req, input logic [3:0] exp_be,
                                input logic [31:0] exp_wdata, exp_rd);
        vec_t v;
        v.mr = mr; v.mw = mw; v.rw = rw; v.m2r = m2r; v.f3 = f3;
        v.addr = addr; v.wd = wd; v.rdata = rdata; v.rd = r; v.lat = lat;
        v.exp_req = exp_req; v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_rd = exp_rd;
        return v;
    endfunction

    // Behavioural model: sizes in bytes, offsets rounded down to the access size.
    function automatic int m_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic int m_off(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = m_size(f3);
        if (sz == 0) return 0;
        return (int'(addr % 4) / sz) * sz;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = m_size(f3);
        if (f3 > 3'd2) return 4'd0;
        return 4'(((1 << sz) - 1) << m_off(f3, addr));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'd0) return (wd & 32'hFF) * 32'h01010101;
        if (f3 == 3'd1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        logic [31:0] v;
        int sz;
        sz = m_size(f3);
        if (sz == 0 || f3 == 3'd6 || f3 == 3'd7) return 32'h0;
        if (sz == 4) return rdata;
        v = (rdata >> (8 * m_off(f3, addr))) & ((32'h1 << (8 * sz)) - 1);
        if (f3 < 3'd4 && v >= (32'h1 << (8 * sz - 1)))
            v = v - (32'h1 << (8 * sz));
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string nm);
        MemRead   = v.mr;
        MemWrite  = v.mw;
        RegWrite  = v.rw;
        MemtoReg  = v.m2r;
        funct3    = v.f3;
        result    = v.addr;
        writeData = v.wd;
        rd        = v.rd;
        dmem_bus.ready = v.exp_req && (v.lat == 0);
        dmem_bus.rdata = (v.exp_req && v.lat == 0) ? v.rdata : 32'h0;
        #1;
        chk({nm, "_req"}, dmem_bus.req, v.exp_req);
        if (v.exp_req) begin
            chk({nm, "_addr"}, dmem_bus.addr, v.addr & ~32'h3);
            chk({nm, "_we"}, dmem_bus.we, v.mw);
        end
        if (v.exp_req && v.mw) begin
            chk({nm, "_be"}, dmem_bus.be, v.exp_be);
            chk({nm, "_wdata"}, dmem_bus.wdata, v.exp_wdata);
        end
        if (v.exp_req) begin
            for (int k = 0; k < v.lat; k++) begin
                chk({nm, "_stall"}, stall, 1'b1);
                if (k > 0) chk({nm, "_req_held"}, dmem_bus.req, 1'b1);
                @(posedge clk); #1;
                chk({nm, "_bubble"}, {RegWrite_wb, MemtoReg_wb, rd_wb}, 7'd0);
            end
            if (v.lat > 0) begin
                dmem_bus.ready = 1'b1;
                dmem_bus.rdata = v.rdata;
                #1;
            end
        end
        chk({nm, "_stall_done"}, stall, 1'b0);
        chk({nm, "_no_buserr"}, bus_error, 1'b0);
        @(posedge clk); #1;
        dmem_bus.ready = 1'b0;
        chk({nm, "_wb_ctl"}, {RegWrite_wb, MemtoReg_wb, rd_wb}, {v.rw, v.m2r, v.rd});
        chk({nm, "_wb_result"}, result_wb, v.addr);
        chk({nm, "_wb_rdata"}, readData_wb, v.exp_rd);
        $display("txn %s mr=%0b mw=%0b f3=%0d addr=%h lat=%0d rdata_wb=%h", nm, v.mr, v.mw,
                 v.f3, v.addr, v.lat, readData_wb);
    endtask

    task automatic go_idle();
        MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0; MemtoReg = 1'b0;
        rd = 5'd0; result = 32'h0; writeData = 32'h0; funct3 = 3'd0;
        dmem_bus.ready = 1'b0; dmem_bus.rdata = 32'h0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs[$];
    vec_t rv;
    int   kind;
    logic [2:0] lf3 [6];
    logic [2:0] sf3 [4];
    int   stall_cnt;
    logic saw_err;

    initial begin
        lf3[0] = 3'd0; lf3[1] = 3'd1; lf3[2] = 3'd2; lf3[3] = 3'd4; lf3[4] = 3'd5; lf3[5] = 3'd3;
        sf3[0] = 3'd0; sf3[1] = 3'd1; sf3[2] = 3'd2; sf3[3] = 3'd3;

        //            mr mw rw m2r f3    addr          wd            rdata         rd lat  req be      wdata         rdata_wb
        vecs.push_back(mk(0, 1, 0, 0, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0,   1, 4'hF, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 3'd0, 32'h103, 32'h000000A5, 32'h0,        0, 0,   1, 4'h8, 32'hA5A5A5A5, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 3'd1, 32'h102, 32'h00001234, 32'h0,        0, 1,   1, 4'hC, 32'h12341234, 32'h0));
        vecs.push_back(mk(1, 0, 1, 1, 3'd0, 32'h102, 32'h0,        32'h0080FF00, 5, 3,   1, 4'h0, 32'h0,        32'hFFFFFF80));
        vecs.push_back(mk(1, 0, 1, 1, 3'd4, 32'h102, 32'h0,        32'h0080FF00, 6, 3,   1, 4'h0, 32'h0,        32'h00000080));
        vecs.push_back(mk(1, 0, 1, 1, 3'd1, 32'h100, 32'h0,        32'h00008001, 7, 0,   1, 4'h0, 32'h0,        32'hFFFF8001));
        vecs.push_back(mk(1, 0, 1, 1, 3'd5, 32'h102, 32'h0,        32'hABCD1234, 8, 2,   1, 4'h0, 32'h0,        32'h0000ABCD));
        vecs.push_back(mk(1, 0, 1, 1, 3'd2, 32'h104, 32'h0,        32'h12345678, 9, 0,   1, 4'h0, 32'h0,        32'h12345678));
        vecs.push_back(mk(0, 0, 1, 0, 3'd0, 32'h55,  32'h0,        32'h0,       10, 0,   0, 4'h0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 3'd3, 32'h80,  32'h11111111, 32'h0,        0, 0,   0, 4'h0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 1, 0, 0, 3'd2, 32'h200, 32'hCAFEF00D, 32'h77777777, 0, 0,   1, 4'hF, 32'hCAFEF00D, 32'h0));
        vecs.push_back(mk(1, 0, 1, 0, 3'd3, 32'h40,  32'h0,        32'hFFFFFFFF, 3, 1,   1, 4'h0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 1, 1, 3'd2, 32'h300, 32'h0,        32'h5A5A0F0F, 4, TO + 1, 1, 4'h0, 32'h0, 32'h5A5A0F0F));
`ifndef MEM_MISALIGN_TRAP_EN
        vecs.push_back(mk(1, 0, 1, 1, 3'd1, 32'h103, 32'h0,        32'hBEEF0000, 11, 0,  1, 4'h0, 32'h0,        32'hFFFFBEEF));
        vecs.push_back(mk(0, 1, 0, 0, 3'd2, 32'h102, 32'h01020304, 32'h0,        0, 0,   1, 4'hF, 32'h01020304, 32'h0));
`endif

        // Reset: outputs cleared, request/stall gated even with an access presented.
        rstn = 1'b0;
        go_idle();
        MemRead = 1'b1; funct3 = 3'd2; result = 32'h10;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_req_gated", dmem_bus.req, 1'b0);
        chk("reset_stall_gated", stall, 1'b0);
        chk("reset_wb", {RegWrite_wb, MemtoReg_wb, rd_wb, result_wb, readData_wb}, 71'd0);
        rstn = 1'b1;
        go_idle();
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            rv.mr  = (kind == 1) || (kind == 3);
            rv.mw  = (kind == 2) || (kind == 3);
            rv.f3  = rv.mw ? sf3[$urandom_range(0, 3)] : lf3[$urandom_range(0, 5)];
            rv.addr = $urandom & 32'h0000_0FFF;
`ifdef MEM_MISALIGN_TRAP_EN
            if (m_size(rv.f3) != 0) rv.addr = rv.addr & ~(32'(m_size(rv.f3)) - 1);
`endif
            rv.wd    = $urandom;
            rv.rdata = $urandom;
            rv.rd    = 5'($urandom_range(1, 31));
            rv.rw    = 1'($urandom);
            rv.m2r   = 1'($urandom);
            rv.lat   = $urandom_range(0, 4);
            rv.exp_req   = rv.mw ? (rv.f3 <= 3'd2) : rv.mr;
            rv.exp_be    = m_be(rv.f3, rv.addr);
            rv.exp_wdata = m_wdata(rv.f3, rv.wd);
            rv.exp_rd    = (rv.mr && !rv.mw) ? m_load(rv.f3, rv.addr, rv.rdata) : 32'h0;
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        // Timeout: ready never comes; the abort cycle drops stall and pulses bus_error.
        go_idle();
        MemRead = 1'b1; RegWrite = 1'b1; MemtoReg = 1'b1; rd = 5'd12;
        funct3 = 3'd2; result = 32'h44;
        #1;
        stall_cnt = 0;
        saw_err = 1'b0;
        for (int i = 0; i < TO + 10; i++) begin
            if (bus_error) begin
                saw_err = 1'b1;
                break;
            end
            if (stall) stall_cnt++;
            @(posedge clk); #1;
        end
        chk("timeout_bus_error", saw_err, 1'b1);
        chk("timeout_stall_cycles", stall_cnt, TO + 1);
        chk("timeout_abort_stall", stall, 1'b0);
        @(posedge clk); #1;
        go_idle();
        #1;
        chk("timeout_wb_bubble", {RegWrite_wb, MemtoReg_wb, rd_wb}, 7'd0);
        chk("timeout_pulse_once", bus_error, 1'b0);
        chk("timeout_idle_req", dmem_bus.req, 1'b0);
        $display("txn timeout stall_cycles=%0d", stall_cnt);
        @(posedge clk); #1;

        // Reset during WAIT abandons the access even if ready shows up at that edge.
        MemRead = 1'b1; RegWrite = 1'b1; rd = 5'd3; funct3 = 3'd2; result = 32'h60;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        chk("rstwait_in_wait", stall, 1'b1);
        rstn = 1'b0;
        dmem_bus.ready = 1'b1;
        dmem_bus.rdata = 32'h13579BDF;
        #1;
        chk("rstwait_req_gated", dmem_bus.req, 1'b0);
        chk("rstwait_stall_gated", stall, 1'b0);
        @(posedge clk); #1;
        rstn = 1'b1;
        go_idle();
        #1;
        chk("rstwait_req", dmem_bus.req, 1'b0);
        chk("rstwait_stall", stall, 1'b0);
        chk("rstwait_wb", {RegWrite_wb, MemtoReg_wb, rd_wb, result_wb, readData_wb}, 71'd0);
        $display("txn reset_during_wait");
        @(posedge clk); #1;

`ifdef MEM_MISALIGN_TRAP_EN
        MemRead = 1'b1; RegWrite = 1'b1; rd = 5'd4; funct3 = 3'd2; result = 32'h101;
        #1;
        chk("misalign_no_req", dmem_bus.req, 1'b0);
        chk("misalign_no_stall", stall, 1'b0);
        @(posedge clk); #1;
        go_idle();
        chk("misalign_pulse", misalign, 1'b1);
        chk("misalign_bubble", {RegWrite_wb, rd_wb}, 6'd0);
        @(posedge clk); #1;
        chk("misalign_one_cycle", misalign, 1'b0);
        $display("txn misaligned_lw");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
